// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants, FSM encoding and state helpers
// for the ChaCha keystream engine.
package chacha_pkg;

    localparam logic [31:0] SIGMA0 = 32'h6170_7865;
    localparam logic [31:0] SIGMA1 = 32'h3320_646e;
    localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
    localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

    typedef logic [15:0][31:0] state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_READY
    } fsm_t;

    // {a,b,c,d} word indices for each quarter-round slot
    function automatic logic [15:0] qr_tbl(input logic [2:0] idx);
        logic [15:0] r;
        unique case (idx)
            3'd0: r = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1: r = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2: r = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3: r = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4: r = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5: r = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6: r = {4'd2, 4'd7, 4'd8,  4'd13};
            3'd7: r = {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
        return r;
    endfunction

    function automatic state_t init_state(
        input logic [255:0] key,
        input logic [31:0]  ctr,
        input logic [95:0]  nonce
    );
        state_t s;
        s[0] = SIGMA0;
        s[1] = SIGMA1;
        s[2] = SIGMA2;
        s[3] = SIGMA3;
        for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
        return s;
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// chacha_qr: one combinational ChaCha quarter-round
// over four 32-bit words.
module chacha_qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] qc,
    output logic [31:0] qd
);

    logic [31:0] a1, b1, c1, d1, d1r, b1r;
    logic [31:0] a2, b2, c2, d2, d2r, b2r;

    // add / xor / rotate chain: 16, 12, 8, 7
    always_comb begin
        a1  = a + b;
        d1  = d ^ a1;
        d1r = {d1[15:0], d1[31:16]};
        c1  = c + d1r;
        b1  = b ^ c1;
        b1r = {b1[19:0], b1[31:20]};
        a2  = a1 + b1r;
        d2  = d1r ^ a2;
        d2r = {d2[23:0], d2[31:24]};
        c2  = c1 + d2r;
        b2  = b1r ^ c2;
        b2r = {b2[24:0], b2[31:25]};
    end

    assign qa = a2;
    assign qb = b2r;
    assign qc = c2;
    assign qd = d2r;

endmodule

// File: rtl/chacha_stream.sv
// chacha_stream: serial-load ChaCha keystream engine, one
// quarter-round per cycle, serial block readout.
module chacha_stream
    import chacha_pkg::*;
#(
    parameter int ROUNDS   = 20,
    parameter int DW       = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic          wr_key,
    input  logic          wr_nnc,
    input  logic          wr_ctr,
    input  logic          start,
    input  logic          rd_blk,
    input  logic          hold,
    input  logic          xor_en,
    output logic [DW-1:0] data_out,
    output logic          blk_ready,
    output logic          busy,
    output logic          ctr_wrap
);

    localparam int NQR   = ROUNDS * 4;
    localparam int WORDS = 512 / DW;

    fsm_t state, state_n;

    logic [255:0]    key;
    logic [95:0]     nonce;
    logic [31:0]     ctr;
    logic            armed;
    state_t          ws, ini, ld_state;
    logic [511:0]    out_reg;
    logic [6:0]      qr_cnt, rd_cnt;

    logic [DW+255:0] key_cat;
    logic [DW+95:0]  nnc_cat;
    logic [DW+31:0]  ctr_cat;

    logic acc_key, acc_nnc, acc_ctr;
    logic load, ld_inc, step, fin, shift;
    logic blk_end, wrap_set;
    logic last_qr, last_word;

    logic [3:0]  ix_a, ix_b, ix_c, ix_d;
    logic [31:0] qa, qb, qc, qd;

    assign key_cat = {data_in, key};
    assign nnc_cat = {data_in, nonce};
    assign ctr_cat = {data_in, ctr};

    assign last_qr   = (qr_cnt == 7'(NQR - 1));
    assign last_word = (rd_cnt == 7'(WORDS - 1));

    assign {ix_a, ix_b, ix_c, ix_d} = qr_tbl(qr_cnt[2:0]);

    assign ini      = init_state(key, ctr, nonce);
    assign ld_state = init_state(key, ld_inc ? ctr + 32'd1 : ctr, nonce);

    assign data_out = out_reg[DW-1:0] ^ (xor_en ? data_in : '0);

    chacha_qr u_qr (
        .a  (ws[ix_a]),
        .b  (ws[ix_b]),
        .c  (ws[ix_c]),
        .d  (ws[ix_d]),
        .qa (qa),
        .qb (qb),
        .qc (qc),
        .qd (qd)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // next-state decode and per-cycle datapath strobes
    always_comb begin
        state_n   = state;
        acc_key   = 1'b0;
        acc_nnc   = 1'b0;
        acc_ctr   = 1'b0;
        load      = 1'b0;
        ld_inc    = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        shift     = 1'b0;
        blk_end   = 1'b0;
        wrap_set  = 1'b0;
        blk_ready = (state == S_READY);
        busy      = (state == S_ROUND) || (state == S_FINAL);
        if (!hold) begin
            unique case (state)
                S_IDLE, S_READY: begin
                    if (wr_key || wr_nnc || wr_ctr) begin
                        acc_key = wr_key;
                        acc_nnc = !wr_key && wr_nnc;
                        acc_ctr = !wr_key && !wr_nnc && wr_ctr;
                        state_n = S_IDLE;
                    end else if (start && armed) begin
                        load    = 1'b1;
                        state_n = S_ROUND;
                    end else if (rd_blk && state == S_READY) begin
                        shift = 1'b1;
                        if (last_word) begin
                            state_n = S_IDLE;
                            if (AUTO_INC) begin
                                blk_end = 1'b1;
                                if (ctr == 32'hFFFF_FFFF) begin
                                    wrap_set = 1'b1;
                                end else begin
                                    load    = 1'b1;
                                    ld_inc  = 1'b1;
                                    state_n = S_ROUND;
                                end
                            end
                        end
                    end
                end
                S_ROUND: begin
                    step = 1'b1;
                    if (last_qr) state_n = S_FINAL;
                end
                S_FINAL: begin
                    fin     = 1'b1;
                    state_n = S_READY;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // key / nonce / counter shift registers and wrap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            key      <= '0;
            nonce    <= '0;
            ctr      <= '0;
            armed    <= 1'b0;
            ctr_wrap <= 1'b0;
        end else begin
            if (acc_key) key <= key_cat[DW+255:DW];
            if (acc_nnc) nonce <= nnc_cat[DW+95:DW];
            if (acc_ctr) begin
                ctr      <= ctr_cat[DW+31:DW];
                ctr_wrap <= 1'b0;
            end
            if (acc_key || acc_nnc || acc_ctr) armed <= 1'b1;
            if (blk_end) ctr <= ctr + 32'd1;
            if (wrap_set) ctr_wrap <= 1'b1;
        end
    end

    // working state, output block and sequencing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            ws      <= '0;
            out_reg <= '0;
            qr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (step) begin
                ws[ix_a] <= qa;
                ws[ix_b] <= qb;
                ws[ix_c] <= qc;
                ws[ix_d] <= qd;
                qr_cnt   <= qr_cnt + 7'd1;
            end
            if (fin) begin
                for (int i = 0; i < 16; i++)
                    out_reg[32*i +: 32] <= ws[i] + ini[i];
            end
            if (shift) begin
                out_reg <= out_reg >> DW;
                rd_cnt  <= rd_cnt + 7'd1;
            end
            if (load) begin
                ws     <= ld_state;
                qr_cnt <= '0;
                rd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_chacha_stream.sv
// tb_chacha_stream: random and RFC 8439 vectors against
// a behavioural ChaCha block model.
module tb_chacha_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic [7:0]  a_din = '0;
    logic [7:0]  a_dout;
    logic a_wk = 0, a_wn = 0, a_wc = 0, a_st = 0;
    logic a_rd = 0, a_hold = 0, a_xor = 0;
    logic a_rdy, a_busy, a_wrap;

    logic [31:0] b_din = '0;
    logic [31:0] b_dout;
    logic b_wk = 0, b_wn = 0, b_wc = 0, b_st = 0;
    logic b_rd = 0, b_hold = 0, b_xor = 0;
    logic b_rdy, b_busy, b_wrap;

    int n_chk = 0;
    int n_err = 0;

    chacha_stream #(.ROUNDS(20), .DW(8), .AUTO_INC(1'b1)) u_a (
        .clk(clk), .rst(rst), .data_in(a_din),
        .wr_key(a_wk), .wr_nnc(a_wn), .wr_ctr(a_wc),
        .start(a_st), .rd_blk(a_rd), .hold(a_hold),
        .xor_en(a_xor), .data_out(a_dout),
        .blk_ready(a_rdy), .busy(a_busy), .ctr_wrap(a_wrap)
    );

    chacha_stream #(.ROUNDS(8), .DW(32), .AUTO_INC(1'b0)) u_b (
        .clk(clk), .rst(rst), .data_in(b_din),
        .wr_key(b_wk), .wr_nnc(b_wn), .wr_ctr(b_wc),
        .start(b_st), .rd_blk(b_rd), .hold(b_hold),
        .xor_en(b_xor), .data_out(b_dout),
        .blk_ready(b_rdy), .busy(b_busy), .ctr_wrap(b_wrap)
    );

    task automatic chk(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr4(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k,
                                               input logic [95:0] n,
                                               input logic [31:0] c,
                                               input int rounds);
        logic [31:0] s[16];
        logic [31:0] x[16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        for (int i = 0; i < 16; i++) x[i] = s[i];
        for (int dr = 0; dr < rounds / 2; dr++) begin
            {x[0], x[4], x[8],  x[12]} = qr4(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr4(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr4(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr4(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr4(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr4(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr4(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr4(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic a_wctr(input logic [31:0] c);
        for (int i = 0; i < 4; i++) begin
            a_din = c[8*i +: 8]; a_wc = 1; tick();
        end
        a_wc = 0;
    endtask

    task automatic a_load(input logic [255:0] k,
                          input logic [95:0] n,
                          input logic [31:0] c);
        for (int i = 0; i < 32; i++) begin
            a_din = k[8*i +: 8]; a_wk = 1; tick();
        end
        a_wk = 0;
        for (int i = 0; i < 12; i++) begin
            a_din = n[8*i +: 8]; a_wn = 1; tick();
        end
        a_wn = 0;
        a_wctr(c);
    endtask

    // counts edges from n0 until blk_ready; optional hold window
    task automatic a_wait(input int n0, input int h_at,
                          input int h_len, output int n);
        n = n0;
        do begin
            tick();
            n++;
            a_st = 0;
            a_hold = (n >= h_at) && (n < h_at + h_len);
        end while (!a_rdy && n < 400);
        a_hold = 0;
        chk("a_ready", a_rdy, 1);
    endtask

    // mode 0: plain, 1: xor 0xFF, 2: xor random
    task automatic a_read(input string tag, input logic [511:0] ks,
                          input int mode, output logic [511:0] got);
        logic [511:0] exp;
        got = '0;
        exp = '0;
        for (int i = 0; i < 64; i++) begin
            a_rd  = 1;
            a_xor = (mode != 0);
            a_din = (mode == 1) ? 8'hFF :
                    (mode == 2) ? 8'($urandom) : 8'h00;
            #1;
            got[8*i +: 8] = a_dout;
            exp[8*i +: 8] = ks[8*i +: 8] ^ (a_xor ? a_din : 8'h00);
            @(posedge clk); #1;
        end
        a_rd = 0; a_xor = 0; a_din = 0;
        chk(tag, got, exp);
    endtask

    task automatic b_load(input logic [255:0] k,
                          input logic [95:0] n,
                          input logic [31:0] c);
        for (int i = 0; i < 8; i++) begin
            b_din = k[32*i +: 32]; b_wk = 1; tick();
        end
        b_wk = 0;
        for (int i = 0; i < 3; i++) begin
            b_din = n[32*i +: 32]; b_wn = 1; tick();
        end
        b_wn = 0;
        b_din = c; b_wc = 1; tick();
        b_wc = 0;
    endtask

    task automatic b_wait(output int n);
        n = 0;
        do begin
            tick();
            n++;
            b_st = 0;
        end while (!b_rdy && n < 200);
        chk("b_ready", b_rdy, 1);
    endtask

    task automatic b_read(input string tag, input logic [511:0] ks,
                          input bit rnd);
        logic [511:0] got, exp;
        got = '0;
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            b_rd  = 1;
            b_xor = rnd;
            b_din = rnd ? $urandom : 32'h0;
            #1;
            got[32*i +: 32] = b_dout;
            exp[32*i +: 32] = ks[32*i +: 32] ^ (rnd ? b_din : 32'h0);
            @(posedge clk); #1;
        end
        b_rd = 0; b_xor = 0; b_din = 0;
        chk(tag, got, exp);
    endtask

    logic [255:0] rk, k2, k3;
    logic [95:0]  rn, n2, n3;
    logic [31:0]  c2, c3;
    logic [511:0] got;
    int lat;

    initial begin
        for (int i = 0; i < 32; i++) rk[8*i +: 8] = 8'(i);
        rn = 96'h00000000_4a000000_09000000;

        // reset state
        tick(); tick();
        rst = 0;
        chk("rst_rdy", a_rdy, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_b_dout", b_dout, 0);
        chk("rst_b_rdy", b_rdy, 0);

        // start before any load is ignored
        a_st = 1; tick(); a_st = 0; tick();
        chk("start_unarmed", a_busy, 0);

        // RFC vector, keystream inverted through xor 0xFF
        a_load(rk, rn, 32'd1);
        a_st = 1;
        a_wait(0, 0, 0, lat);
        chk("lat_start", lat, 82);
        a_read("rfc_xor_ff", ref_block(rk, rn, 1, 20), 1, got);
        chk("rfc_xor_b0", got[7:0], 8'hef);
        chk("auto_busy", a_busy, 1);
        chk("auto_rdy", a_rdy, 0);
        a_wait(1, 0, 0, lat);
        chk("lat_auto", lat, 82);

        // start in READY restarts at the current counter
        a_st = 1;
        a_wait(0, 0, 0, lat);
        chk("lat_restart", lat, 82);
        a_read("ctr2_rnd", ref_block(rk, rn, 2, 20), 2, got);
        a_wait(1, 0, 0, lat);

        // counter write in READY drops blk_ready
        a_din = 8'h01; a_wc = 1; tick();
        chk("wr_drops_rdy", a_rdy, 0);
        a_din = 8'h00; tick(); tick(); tick();
        a_wc = 0;
        a_st = 1;
        a_wait(0, 0, 0, lat);
        a_read("rfc_plain", ref_block(rk, rn, 1, 20), 0, got);
        chk("rfc_first16", got[127:0],
            128'hc47120a3_1fdd0f50_15593bd1_e4e7f110);

        // hold for 10 cycles mid-ROUND
        a_wait(1, 20, 10, lat);
        chk("lat_hold", lat, 92);
        a_read("hold_blk", ref_block(rk, rn, 2, 20), 2, got);
        a_wait(1, 0, 0, lat);

        // counter wrap
        a_wctr(32'hFFFF_FFFE);
        a_st = 1;
        a_wait(0, 0, 0, lat);
        a_read("ctr_fe", ref_block(rk, rn, 32'hFFFF_FFFE, 20), 0, got);
        a_wait(1, 0, 0, lat);
        a_read("ctr_ff", ref_block(rk, rn, 32'hFFFF_FFFF, 20), 2, got);
        chk("wrap_set", a_wrap, 1);
        chk("wrap_rdy", a_rdy, 0);
        chk("wrap_busy", a_busy, 0);
        tick(); tick();
        chk("wrap_idle", a_busy, 0);
        a_st = 1;
        a_wait(0, 0, 0, lat);
        a_read("ctr_0", ref_block(rk, rn, 0, 20), 0, got);
        chk("wrap_sticky", a_wrap, 1);
        a_wait(1, 0, 0, lat);
        a_wctr(32'd5);
        chk("wrap_clear", a_wrap, 0);

        // simultaneous writes: key wins, nonce/ctr kept
        k2 = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        n2 = {$urandom, $urandom, $urandom};
        c2 = $urandom & 32'h7FFF_FFFF;
        a_load(rk, n2, c2);
        for (int i = 0; i < 32; i++) begin
            a_din = k2[8*i +: 8];
            a_wk = 1; a_wn = 1; a_wc = 1;
            tick();
        end
        a_wk = 0; a_wn = 0; a_wc = 0;
        a_st = 1;
        a_wait(0, 0, 0, lat);
        a_read("prio_rnd", ref_block(k2, n2, c2, 20), 2, got);
        a_wait(1, 0, 0, lat);
        a_read("prio_inc", ref_block(k2, n2, c2 + 1, 20), 0, got);
        a_wait(1, 0, 0, lat);

        // reset in the middle of ROUND
        a_st = 1;
        for (int i = 0; i < 40; i++) begin
            tick(); a_st = 0;
        end
        rst = 1; tick(); rst = 0;
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_rdy", a_rdy, 0);
        chk("mid_rst_dout", a_dout, 0);
        a_st = 1; tick(); a_st = 0; tick(); tick();
        chk("rst_start_ign", a_busy, 0);

        // key writes while busy are dropped
        k3 = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        n3 = {$urandom, $urandom, $urandom};
        c3 = $urandom & 32'h7FFF_FFFF;
        a_load(k3, n3, c3);
        a_st = 1; tick(); a_st = 0;
        for (int i = 0; i < 20; i++) begin
            a_din = 8'($urandom); a_wk = 1; tick();
        end
        a_wk = 0;
        a_wait(21, 0, 0, lat);
        a_read("busy_wr_key", ref_block(k3, n3, c3, 20), 2, got);

        // DW=32, 8 rounds, no auto-increment
        b_load(rk, rn, 32'd1);
        b_st = 1;
        b_wait(lat);
        chk("b_lat", lat, 34);
        b_read("b_rfc8", ref_block(rk, rn, 1, 8), 0);
        chk("b_end_rdy", b_rdy, 0);
        chk("b_end_busy", b_busy, 0);
        b_load(k3, n3, c3);
        b_st = 1;
        b_wait(lat);
        b_read("b_rnd", ref_block(k3, n3, c3, 8), 1);
        chk("b_wrap", b_wrap, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
